parking_lot_multigate: RTL and testbench

Parametrised occupancy core for the parking-lot system, replacing the single-gate detector/occupancy pair. It serves NUM_GATES independent entry/exit gates, each with an outer and an inner photo-sensor. Per-gate direction FSMs decode car passages, and one shared counter tracks occupancy against CAPACITY. It sits between the V_GPIO sensor pins and the display/LED logic in DE1_SoC.

---
 rtl/parking_pkg.sv | 35 +++
 rtl/parking_gate_fsm.sv | 156 +++++++++++++++
 rtl/parking_lot_multigate.sv | 91 +++++++++
 tb/tb_parking_lot_multigate.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// parking_pkg
// Shared definitions for the multi-gate parking-lot occupancy core.
//   gate_state_t : direction-decoder states of one gate
//   ACC_GUARD    : extra bits on the signed occupancy accumulator
//   MAX_GATES    : widest gate vector the popcount helper handles
//   POP_W        : width of a popcount result over MAX_GATES bits
//   popcount()   : number of set bits in a gate pulse vector
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EN_O,
    EN_OI,
    EN_I,
    EX_I,
    EX_OI,
    EX_O
  } gate_state_t;

  // Four guard bits keep count + up-to-8 entries (or count - 8 exits)
  // representable without wrap before the clamp.
  localparam int ACC_GUARD = 4;
  localparam int MAX_GATES = 8;
  localparam int POP_W     = 4;

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_GATES-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int k = 0; k < MAX_GATES; k++) begin
      n = n + POP_W'(v[k]);
    end
    return n;
  endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// parking_gate_fsm
// One gate's sensor synchroniser and direction decoder.
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset
//   o        in  asynchronous outer-sensor level, 1 = beam blocked
//   i        in  asynchronous inner-sensor level, 1 = beam blocked
//   enter_p  out one-cycle pulse when an entry completes
//   exit_p   out one-cycle pulse when an exit completes
//   abort_p  out one-cycle pulse on an illegal sensor sequence
module parking_gate_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic o,
  input  logic i,
  output logic enter_p,
  output logic exit_p,
  output logic abort_p
);

  logic        o_meta;
  logic        o_sync;
  logic        i_meta;
  logic        i_sync;
  logic [1:0]  pair;

  gate_state_t state;
  gate_state_t state_nxt;
  logic        locked;
  logic        locked_nxt;
  logic        illegal;
  logic        enter_d;
  logic        exit_d;
  logic        abort_d;

  // Two-flop synchronisers bring the raw sensor levels into the clock domain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_meta <= 1'b0;
      o_sync <= 1'b0;
      i_meta <= 1'b0;
      i_sync <= 1'b0;
    end else begin
      o_meta <= o;
      o_sync <= o_meta;
      i_meta <= i;
      i_sync <= i_meta;
    end
  end

  assign pair = {o_sync, i_sync};

  // State register; the pulses are registered so each lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      locked  <= 1'b0;
      enter_p <= 1'b0;
      exit_p  <= 1'b0;
      abort_p <= 1'b0;
    end else begin
      state   <= state_nxt;
      locked  <= locked_nxt;
      enter_p <= enter_d;
      exit_p  <= exit_d;
      abort_p <= abort_d;
    end
  end

  // Next-state decode. Forward steps advance, a single step back retreats,
  // holding the pattern stays put, anything else is illegal.
  always_comb begin
    state_nxt  = state;
    locked_nxt = locked;
    illegal    = 1'b0;
    case (state)
      IDLE: begin
        // After an abort the gate ignores everything until it reads 00,
        // so a car stuck between the beams does not re-arm the decoder.
        if (locked) begin
          if (pair == 2'b00) locked_nxt = 1'b0;
        end else begin
          case (pair)
            2'b00:   state_nxt = IDLE;
            2'b10:   state_nxt = EN_O;
            2'b01:   state_nxt = EX_I;
            default: illegal   = 1'b1;
          endcase
        end
      end
      EN_O: begin
        case (pair)
          2'b10:   state_nxt = EN_O;
          2'b11:   state_nxt = EN_OI;
          2'b00:   state_nxt = IDLE;
          default: illegal   = 1'b1;
        endcase
      end
      EN_OI: begin
        case (pair)
          2'b11:   state_nxt = EN_OI;
          2'b01:   state_nxt = EN_I;
          2'b10:   state_nxt = EN_O;
          default: illegal   = 1'b1;
        endcase
      end
      EN_I: begin
        case (pair)
          2'b01:   state_nxt = EN_I;
          2'b00:   state_nxt = IDLE;
          2'b11:   state_nxt = EN_OI;
          default: illegal   = 1'b1;
        endcase
      end
      EX_I: begin
        case (pair)
          2'b01:   state_nxt = EX_I;
          2'b11:   state_nxt = EX_OI;
          2'b00:   state_nxt = IDLE;
          default: illegal   = 1'b1;
        endcase
      end
      EX_OI: begin
        case (pair)
          2'b11:   state_nxt = EX_OI;
          2'b10:   state_nxt = EX_O;
          2'b01:   state_nxt = EX_I;
          default: illegal   = 1'b1;
        endcase
      end
      EX_O: begin
        case (pair)
          2'b10:   state_nxt = EX_O;
          2'b00:   state_nxt = IDLE;
          2'b11:   state_nxt = EX_OI;
          default: illegal   = 1'b1;
        endcase
      end
      default: state_nxt = IDLE;
    endcase
    // An abort on a 00 pattern needs no lockout; the gate is already clear.
    if (illegal) begin
      state_nxt  = IDLE;
      locked_nxt = (pair != 2'b00);
    end
  end

  // Output decode: a passage completes when the last beam clears.
  always_comb begin
    enter_d = (state == EN_I) && (pair == 2'b00);
    exit_d  = (state == EX_O) && (pair == 2'b00);
    abort_d = illegal;
  end

endmodule

// File: rtl/parking_lot_multigate.sv
// parking_lot_multigate
// Occupancy core serving NUM_GATES entry/exit gates against CAPACITY.
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset
//   outer    in  per-gate outer-sensor levels, 1 = beam blocked
//   inner    in  per-gate inner-sensor levels, 1 = beam blocked
//   enter_p  out per-gate one-cycle entry pulses
//   exit_p   out per-gate one-cycle exit pulses
//   abort_p  out per-gate one-cycle illegal-sequence pulses
//   count    out current occupancy
//   full     out count == CAPACITY
//   empty    out count == 0
//   ovf_err  out sticky over/underflow flag, cleared only by reset
module parking_lot_multigate
  import parking_pkg::*;
#(
  parameter  int NUM_GATES = 2,
  parameter  int CAPACITY  = 25,
  localparam int CW        = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_GATES-1:0] outer,
  input  logic [NUM_GATES-1:0] inner,
  output logic [NUM_GATES-1:0] enter_p,
  output logic [NUM_GATES-1:0] exit_p,
  output logic [NUM_GATES-1:0] abort_p,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf_err
);

  localparam int AW = CW + ACC_GUARD;
  localparam logic signed [AW-1:0] CAP_S = AW'(CAPACITY);

  logic [MAX_GATES-1:0]   enter_vec;
  logic [MAX_GATES-1:0]   exit_vec;
  logic [POP_W-1:0]       e_cnt;
  logic [POP_W-1:0]       x_cnt;
  logic signed [AW-1:0]   acc;
  logic                   under;
  logic                   over;
  logic [CW-1:0]          count_nxt;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    parking_gate_fsm u_gate (
      .clk     (clk),
      .reset_n (reset_n),
      .o       (outer[g]),
      .i       (inner[g]),
      .enter_p (enter_p[g]),
      .exit_p  (exit_p[g]),
      .abort_p (abort_p[g])
    );
  end

  assign enter_vec = MAX_GATES'(enter_p);
  assign exit_vec  = MAX_GATES'(exit_p);
  assign e_cnt     = popcount(enter_vec);
  assign x_cnt     = popcount(exit_vec);

  // Net all gate events in one signed sum, then clamp; an out-of-range
  // intermediate is what raises the sticky error.
  always_comb begin
    acc   = signed'(AW'(count) + AW'(e_cnt) - AW'(x_cnt));
    under = acc[AW-1];
    over  = !under && (acc > CAP_S);
    if (under) begin
      count_nxt = '0;
    end else if (over) begin
      count_nxt = CW'(CAPACITY);
    end else begin
      count_nxt = acc[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      count   <= count_nxt;
      ovf_err <= ovf_err | under | over;
    end
  end

  assign full  = (count == CW'(CAPACITY));
  assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lot_multigate.sv
// tb_parking_lot_multigate
// Scoreboard bench: every sensor sequence pushes the pulse pattern and the
// resulting occupancy it should cause; a negedge monitor pops and compares.
module tb_parking_lot_multigate;

  localparam int NG  = 2;
  localparam int CAP = 3;
  localparam int CW  = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NG-1:0] outer;
  logic [NG-1:0] inner;
  logic [NG-1:0] enter_p;
  logic [NG-1:0] exit_p;
  logic [NG-1:0] abort_p;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          ovf_err;

  typedef struct {
    logic [NG-1:0] en;
    logic [NG-1:0] ex;
    logic [NG-1:0] ab;
    int            cnt;
    logic          ovf;
  } event_t;

  event_t exp_q[$];
  event_t cur_ev;
  int     checks      = 0;
  int     errors      = 0;
  int     model_count = 0;
  logic   model_ovf   = 1'b0;
  logic   count_due   = 1'b0;
  int     due_count   = 0;
  logic   due_ovf     = 1'b0;

  parking_lot_multigate #(
    .NUM_GATES (NG),
    .CAPACITY  (CAP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .outer   (outer),
    .inner   (inner),
    .enter_p (enter_p),
    .exit_p  (exit_p),
    .abort_p (abort_p),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .ovf_err (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Independent occupancy model: clamp to 0..CAP, sticky error on overshoot.
  task automatic expectEvent(input logic [NG-1:0] en, input logic [NG-1:0] ex,
                             input logic [NG-1:0] ab);
    event_t e;
    int     acc;
    acc = model_count + $countones(en) - $countones(ex);
    if (acc < 0) begin
      acc       = 0;
      model_ovf = 1'b1;
    end else if (acc > CAP) begin
      acc       = CAP;
      model_ovf = 1'b1;
    end
    model_count = acc;
    e.en  = en;
    e.ex  = ex;
    e.ab  = ab;
    e.cnt = acc;
    e.ovf = model_ovf;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [NG-1:0] o_pat, input logic [NG-1:0] i_pat);
    outer = o_pat;
    inner = i_pat;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic enterGate(input int g);
    logic [NG-1:0] m;
    m = NG'(1) << g;
    applyStimulus(m, '0);
    applyStimulus(m, m);
    applyStimulus('0, m);
    expectEvent(m, '0, '0);
    applyStimulus('0, '0);
  endtask

  task automatic exitGate(input int g);
    logic [NG-1:0] m;
    m = NG'(1) << g;
    applyStimulus('0, m);
    applyStimulus(m, m);
    applyStimulus(m, '0);
    expectEvent('0, m, '0);
    applyStimulus('0, '0);
  endtask

  task automatic checkDrain(input string tag);
    for (int k = 0; k < 16; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput(tag, exp_q.size(), 0);
  endtask

  task automatic checkIdle(input string tag, input int exp_count, input logic exp_ovf);
    checkOutput({tag, "_count"}, count, exp_count);
    checkOutput({tag, "_empty"}, empty, exp_count == 0);
    checkOutput({tag, "_full"}, full, exp_count == CAP);
    checkOutput({tag, "_ovf"}, ovf_err, exp_ovf);
    checkOutput({tag, "_pulses"}, {enter_p, exit_p, abort_p}, 0);
  endtask

  // Monitor: a pulse cycle pops one scoreboard entry; the following cycle
  // checks the registered occupancy and flags that the pulse should cause.
  always @(negedge clk) begin
    if (count_due) begin
      checkOutput("count", count, due_count);
      checkOutput("full", full, due_count == CAP);
      checkOutput("empty", empty, due_count == 0);
      checkOutput("ovf_err", ovf_err, due_ovf);
      count_due = 1'b0;
    end
    if ((enter_p | exit_p | abort_p) != '0) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pulse", {enter_p, exit_p, abort_p}, 0);
      end else begin
        cur_ev = exp_q.pop_front();
        checkOutput("enter_p", enter_p, cur_ev.en);
        checkOutput("exit_p", exit_p, cur_ev.ex);
        checkOutput("abort_p", abort_p, cur_ev.ab);
        count_due = 1'b1;
        due_count = cur_ev.cnt;
        due_ovf   = cur_ev.ovf;
      end
    end
  end

  initial begin
    outer   = '0;
    inner   = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkIdle("reset", 0, 1'b0);

    // Single entry on gate 0, then single exit on gate 1.
    enterGate(0);
    checkDrain("drain_entry");
    exitGate(1);
    checkDrain("drain_exit");

    // Bring occupancy to 2, then finish an entry and an exit on the same cycle.
    enterGate(0);
    enterGate(0);
    checkDrain("drain_fill2");
    applyStimulus(2'b01, 2'b10);
    applyStimulus(2'b11, 2'b11);
    applyStimulus(2'b10, 2'b01);
    expectEvent(2'b01, 2'b10, 2'b00);
    applyStimulus(2'b00, 2'b00);
    checkDrain("drain_simul");

    // Fill to capacity, overshoot once, then leave one car out.
    enterGate(1);
    enterGate(0);
    exitGate(0);
    checkDrain("drain_full");

    // Illegal jump 10 -> 01 aborts without counting.
    applyStimulus(2'b01, 2'b00);
    expectEvent('0, '0, 2'b01);
    applyStimulus(2'b00, 2'b01);
    applyStimulus(2'b00, 2'b00);
    checkDrain("drain_abort");

    // Car noses in and backs out: nothing is reported.
    applyStimulus(2'b01, 2'b00);
    applyStimulus(2'b01, 2'b01);
    applyStimulus(2'b01, 2'b00);
    applyStimulus(2'b00, 2'b00);
    checkDrain("drain_backout");
    checkIdle("backout", 2, 1'b1);

    // Reset while gate 0 sits between the beams.
    applyStimulus(2'b01, 2'b00);
    applyStimulus(2'b01, 2'b01);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    model_count = 0;
    model_ovf   = 1'b0;
    checkIdle("midreset", 0, 1'b0);
    expectEvent('0, '0, 2'b01);
    applyStimulus(2'b01, 2'b01);
    applyStimulus(2'b00, 2'b01);
    applyStimulus(2'b00, 2'b00);
    checkDrain("drain_midreset");

    // Exit on an empty lot underflows; a later entry still counts.
    exitGate(1);
    enterGate(0);
    checkDrain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
